tilt_char_sequencer: RTL and testbench
======================================

TILT_CHAR_SEQUENCER -- requirements
Module: tilt_char_sequencer

Interface
REQ-001 SHALL have parameter HOLD_SAMPLES, default 4: consecutive matching samples needed to commit a character (legal range 1..255).
REQ-002 SHALL have parameter REPEAT_SAMPLES, default 16: matching samples in WAIT_NEUTRAL before an auto-repeat commit (legal range 1..255; used only with the Configuration macro).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: sequencer run enable.
REQ-006 SHALL have port sample_strobe, input, 1 bit: one-cycle pulse marking a new accelerometer sample decoded by tilt_13.
REQ-007 SHALL have port ascii_in, input, 8 bits: tilt_13 ascii_out.
REQ-008 SHALL have port ascii_in_valid, input, 1 bit: tilt_13 valid; low at a strobe means neutral (no tilt).
REQ-009 SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-010 SHALL have port char_out, output, 8 bits: committed character, registered.
REQ-011 SHALL have port char_valid, output, 1 bit: offer of char_out, registered.
REQ-012 SHALL have port commit_count, output, 16 bits: number of accepted characters.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 SHALL implement the states IDLE, TRACK, COMMIT and WAIT_NEUTRAL.
REQ-015 IDLE: SHALL enter TRACK on the first cycle with enable=1, with candidate cleared and hold counter=0.
REQ-016 TRACK, strobe with ascii_in_valid=1 and ascii_in==candidate: SHALL increment the hold counter; on reaching HOLD_SAMPLES, SHALL go to COMMIT on the next edge.
REQ-017 TRACK, strobe with ascii_in_valid=1 and ascii_in!=candidate: SHALL load ascii_in as candidate and set counter=1 (commits immediately if HOLD_SAMPLES=1).
REQ-018 TRACK, strobe with ascii_in_valid=0: SHALL clear candidate and counter.
REQ-019 Cycles without sample_strobe SHALL leave the candidate and counters unchanged.
REQ-020 COMMIT: char_out=candidate and char_valid=1 SHALL be asserted on the cycle the state becomes COMMIT; both SHALL stay stable until out_ready=1.
REQ-021 Handshake (char_valid & out_ready): SHALL drop char_valid next cycle, increment commit_count (wrapping 0xFFFF->0), and go to WAIT_NEUTRAL.
REQ-022 Strobes arriving during COMMIT SHALL be ignored.
REQ-023 WAIT_NEUTRAL: a strobe with ascii_in_valid=0 SHALL return to TRACK with candidate and counter cleared; valid strobes SHALL be ignored (except REQ-029).
REQ-024 enable=0 in TRACK or WAIT_NEUTRAL SHALL go to IDLE next edge, clearing candidate and counters.
REQ-025 enable=0 in COMMIT SHALL NOT abort the offer: the handshake completes, then the block goes to IDLE instead of WAIT_NEUTRAL.
REQ-026 Latency: from the HOLD_SAMPLES-th matching strobe (edge N), char_valid SHALL be high after edge N+1.
REQ-027 Counters SHALL saturate and never wrap inside a state.

Reset
REQ-028 Reset SHALL asynchronously force IDLE, char_out=8'h00, char_valid=0, commit_count=0, busy=0, and clear candidate and all counters; an in-flight offer is dropped without counting.

Configuration
REQ-029 With TILT_AUTOREPEAT_EN defined: in WAIT_NEUTRAL, strobes with ascii_in_valid=1 and ascii_in==candidate SHALL increment a repeat counter; at REPEAT_SAMPLES the block SHALL go to COMMIT with the same char. Any other strobe SHALL clear the repeat counter, and a neutral strobe still applies REQ-023.
REQ-030 Without TILT_AUTOREPEAT_EN: no repeat counter SHALL exist, and WAIT_NEUTRAL SHALL exit only per REQ-023/REQ-024.

Verification
REQ-031 enable=1, out_ready=1, 4 strobes with 'A' (8'h41) -> one char_valid pulse with char_out=8'h41, commit_count=1.
REQ-032 Strobes A,A,B,B,B,B -> single commit of 'B' only, after the 6th strobe.
REQ-033 'C' held 4 strobes, out_ready=0 for 10 cycles -> char_valid and char_out=8'h43 stable for 10 cycles, count increments once when out_ready rises.
REQ-034 After commit, 20 more 'C' strobes then a neutral strobe, then 4 'C' strobes -> exactly 2 commits without the macro; with TILT_AUTOREPEAT_EN and REPEAT_SAMPLES=16 -> 3 commits.
REQ-035 reset pulsed mid-COMMIT -> char_valid=0, commit_count=0, busy=0 immediately, no clock edge needed.
REQ-036 enable dropped during COMMIT -> offer completes on out_ready, then IDLE with busy=0.

Source files
------------

// File: rtl/tilt_char_sequencer.sv
// rtl/tilt_char_sequencer.sv - debounces tilt_13 characters into committed, handshaken output chars
// Optional feature macro: TILT_AUTOREPEAT_EN (auto-repeat while a tilt is held in WAIT_NEUTRAL)
module tilt_char_sequencer #(
  parameter int HOLD_SAMPLES   = 4,
  parameter int REPEAT_SAMPLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sample_strobe,
  input  logic [7:0]  ascii_in,
  input  logic        ascii_in_valid,
  input  logic        out_ready,
  output logic [7:0]  char_out,
  output logic        char_valid,
  output logic [15:0] commit_count,
  output logic        busy
);

  // Out-of-range parameters would silently break the 8-bit counters.
  if (HOLD_SAMPLES < 1 || HOLD_SAMPLES > 255) begin : g_bad_hold
    $error("HOLD_SAMPLES out of range 1..255");
  end
  if (REPEAT_SAMPLES < 1 || REPEAT_SAMPLES > 255) begin : g_bad_repeat
    $error("REPEAT_SAMPLES out of range 1..255");
  end

  localparam logic [7:0] HOLD_CNT = 8'(HOLD_SAMPLES);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    TRACK        = 2'd1,
    COMMIT       = 2'd2,
    WAIT_NEUTRAL = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cand_q, cand_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  char_out_q, char_out_d;
  logic        char_valid_q, char_valid_d;
  logic [15:0] count_q, count_d;
  // Remembers that enable fell while an offer was pending, so the block parks in IDLE afterwards.
  logic        drop_q, drop_d;

`ifdef TILT_AUTOREPEAT_EN
  localparam logic [7:0] REPEAT_CNT = 8'(REPEAT_SAMPLES);
  logic [7:0]  rep_q, rep_d;
  logic [7:0]  rep_inc;
`endif

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Next-state, candidate tracking and offer/handshake logic.
  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    hold_d       = hold_q;
    char_out_d   = char_out_q;
    char_valid_d = char_valid_q;
    count_d      = count_q;
    drop_d       = drop_q;
`ifdef TILT_AUTOREPEAT_EN
    rep_d        = rep_q;
    rep_inc      = sat_inc(rep_q);
`endif
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = TRACK;
          cand_d  = 8'h00;
          hold_d  = 8'h00;
        end
      end
      TRACK: begin
        if (!enable) begin
          state_d = IDLE;
          cand_d  = 8'h00;
          hold_d  = 8'h00;
        end else if (hold_q >= HOLD_CNT) begin
          // Count reached on the previous edge; offer goes out one edge later.
          state_d      = COMMIT;
          char_out_d   = cand_q;
          char_valid_d = 1'b1;
          drop_d       = 1'b0;
        end else if (sample_strobe) begin
          if (!ascii_in_valid) begin
            cand_d = 8'h00;
            hold_d = 8'h00;
          end else if (ascii_in == cand_q) begin
            hold_d = sat_inc(hold_q);
          end else begin
            cand_d = ascii_in;
            hold_d = 8'h01;
          end
        end
      end
      COMMIT: begin
        if (!enable) begin
          drop_d = 1'b1;
        end
        if (char_valid_q && out_ready) begin
          char_valid_d = 1'b0;
          count_d      = count_q + 16'd1;
          hold_d       = 8'h00;
`ifdef TILT_AUTOREPEAT_EN
          rep_d        = 8'h00;
`endif
          if (drop_q || !enable) begin
            state_d = IDLE;
            cand_d  = 8'h00;
            drop_d  = 1'b0;
          end else begin
            state_d = WAIT_NEUTRAL;
          end
        end
      end
      WAIT_NEUTRAL: begin
        if (!enable) begin
          state_d = IDLE;
          cand_d  = 8'h00;
          hold_d  = 8'h00;
`ifdef TILT_AUTOREPEAT_EN
          rep_d   = 8'h00;
`endif
        end else if (sample_strobe) begin
          if (!ascii_in_valid) begin
            state_d = TRACK;
            cand_d  = 8'h00;
            hold_d  = 8'h00;
`ifdef TILT_AUTOREPEAT_EN
            rep_d   = 8'h00;
`endif
          end
`ifdef TILT_AUTOREPEAT_EN
          else if (ascii_in == cand_q) begin
            if (rep_inc >= REPEAT_CNT) begin
              state_d      = COMMIT;
              char_out_d   = cand_q;
              char_valid_d = 1'b1;
              drop_d       = 1'b0;
              rep_d        = 8'h00;
            end else begin
              rep_d = rep_inc;
            end
          end else begin
            rep_d = 8'h00;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cand_q       <= 8'h00;
      hold_q       <= 8'h00;
      char_out_q   <= 8'h00;
      char_valid_q <= 1'b0;
      count_q      <= 16'h0000;
      drop_q       <= 1'b0;
`ifdef TILT_AUTOREPEAT_EN
      rep_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      hold_q       <= hold_d;
      char_out_q   <= char_out_d;
      char_valid_q <= char_valid_d;
      count_q      <= count_d;
      drop_q       <= drop_d;
`ifdef TILT_AUTOREPEAT_EN
      rep_q        <= rep_d;
`endif
    end
  end

  assign char_out     = char_out_q;
  assign char_valid   = char_valid_q;
  assign commit_count = count_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_tilt_char_sequencer.sv
// tb/tb_tilt_char_sequencer.sv - directed self-checking bench for tilt_char_sequencer
module tb_tilt_char_sequencer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        sample_strobe;
  logic [7:0]  ascii_in;
  logic        ascii_in_valid;
  logic        out_ready;
  logic [7:0]  char_out;
  logic        char_valid;
  logic [15:0] commit_count;
  logic        busy;

  int checks;
  int failures;

  tilt_char_sequencer #(
    .HOLD_SAMPLES(4),
    .REPEAT_SAMPLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .sample_strobe(sample_strobe),
    .ascii_in(ascii_in),
    .ascii_in_valid(ascii_in_valid),
    .out_ready(out_ready),
    .char_out(char_out),
    .char_valid(char_valid),
    .commit_count(commit_count),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] a, input logic v);
    sample_strobe  = 1'b1;
    ascii_in       = a;
    ascii_in_valid = v;
    tick();
    sample_strobe  = 1'b0;
    ascii_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (char_valid !== 1'b0 || char_out !== 8'h00 || commit_count !== 16'h0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b out=%h count=%0d busy=%b, want 0 00 0 0",
               char_valid, char_out, commit_count, busy);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_without_enable: busy=%b want 0", busy);
    end
  endtask

  task automatic test_single_commit();
    enable    = 1'b1;
    out_ready = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL enter_track: busy=%b want 1", busy);
    end
    for (int i = 0; i < 4; i++) strobe(8'h41, 1'b1);
    checks++;
    if (char_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early: valid=%b want 0 right after 4th strobe", char_valid);
    end
    tick();
    checks++;
    if (char_valid !== 1'b1 || char_out !== 8'h41) begin
      failures++;
      $display("FAIL commit_A: valid=%b out=%h want 1 41", char_valid, char_out);
    end
    tick();
    checks++;
    if (char_valid !== 1'b0 || commit_count !== 16'd1) begin
      failures++;
      $display("FAIL handshake_A: valid=%b count=%0d want 0 1", char_valid, commit_count);
    end
  endtask

  task automatic test_candidate_switch();
    strobe(8'h00, 1'b0);
    strobe(8'h41, 1'b1);
    strobe(8'h41, 1'b1);
    strobe(8'h42, 1'b1);
    tick();
    strobe(8'h42, 1'b1);
    tick();
    tick();
    strobe(8'h42, 1'b1);
    checks++;
    if (char_valid !== 1'b0) begin
      failures++;
      $display("FAIL switch_no_early: valid=%b want 0 after 5th strobe", char_valid);
    end
    strobe(8'h42, 1'b1);
    checks++;
    if (char_valid !== 1'b0) begin
      failures++;
      $display("FAIL switch_latency: valid=%b want 0 right after 6th strobe", char_valid);
    end
    tick();
    checks++;
    if (char_valid !== 1'b1 || char_out !== 8'h42) begin
      failures++;
      $display("FAIL commit_B: valid=%b out=%h want 1 42", char_valid, char_out);
    end
    tick();
    checks++;
    if (commit_count !== 16'd2) begin
      failures++;
      $display("FAIL count_after_B: count=%0d want 2", commit_count);
    end
  endtask

  task automatic test_backpressure();
    strobe(8'h00, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) strobe(8'h43, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) strobe(8'h44, 1'b1);
      else tick();
      checks++;
      if (char_valid !== 1'b1 || char_out !== 8'h43 || commit_count !== 16'd2) begin
        failures++;
        $display("FAIL hold_offer[%0d]: valid=%b out=%h count=%0d want 1 43 2",
                 i, char_valid, char_out, commit_count);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (char_valid !== 1'b0 || commit_count !== 16'd3) begin
      failures++;
      $display("FAIL release_offer: valid=%b count=%0d want 0 3", char_valid, commit_count);
    end
  endtask

  task automatic test_wait_neutral();
    for (int i = 0; i < 20; i++) begin
      strobe(8'h43, 1'b1);
      checks++;
      if (char_valid !== 1'b0 || commit_count !== 16'd3) begin
        failures++;
        $display("FAIL no_repeat[%0d]: valid=%b count=%0d want 0 3", i, char_valid, commit_count);
      end
    end
    strobe(8'h00, 1'b0);
    for (int i = 0; i < 4; i++) strobe(8'h43, 1'b1);
    tick();
    checks++;
    if (char_valid !== 1'b1 || char_out !== 8'h43) begin
      failures++;
      $display("FAIL recommit_C: valid=%b out=%h want 1 43", char_valid, char_out);
    end
    tick();
    checks++;
    if (commit_count !== 16'd4) begin
      failures++;
      $display("FAIL count_after_C2: count=%0d want 4", commit_count);
    end
  endtask

  task automatic test_async_reset();
    strobe(8'h00, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) strobe(8'h45, 1'b1);
    tick();
    checks++;
    if (char_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_offer: valid=%b want 1", char_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (char_valid !== 1'b0 || commit_count !== 16'd0 || busy !== 1'b0 || char_out !== 8'h00) begin
      failures++;
      $display("FAIL async_reset: valid=%b count=%0d busy=%b out=%h want 0 0 0 00",
               char_valid, commit_count, busy, char_out);
    end
    #1;
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || commit_count !== 16'd0 || char_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_track: busy=%b count=%0d valid=%b want 1 0 0",
               busy, commit_count, char_valid);
    end
  endtask

  task automatic test_enable_drop_in_commit();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) strobe(8'h46, 1'b1);
    tick();
    enable = 1'b0;
    tick();
    tick();
    checks++;
    if (char_valid !== 1'b1 || char_out !== 8'h46 || busy !== 1'b1) begin
      failures++;
      $display("FAIL offer_survives_disable: valid=%b out=%h busy=%b want 1 46 1",
               char_valid, char_out, busy);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (char_valid !== 1'b0 || commit_count !== 16'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL disable_to_idle: valid=%b count=%0d busy=%b want 0 1 0",
               char_valid, commit_count, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL stay_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_enable_drop_in_track();
    enable = 1'b1;
    tick();
    strobe(8'h47, 1'b1);
    strobe(8'h47, 1'b1);
    enable = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL track_disable: busy=%b want 0", busy);
    end
    enable = 1'b1;
    tick();
    strobe(8'h47, 1'b1);
    strobe(8'h47, 1'b1);
    tick();
    checks++;
    if (char_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_cleared: valid=%b want 0 after only 2 fresh strobes", char_valid);
    end
    strobe(8'h47, 1'b1);
    strobe(8'h47, 1'b1);
    tick();
    checks++;
    if (char_valid !== 1'b1 || char_out !== 8'h47) begin
      failures++;
      $display("FAIL commit_G: valid=%b out=%h want 1 47", char_valid, char_out);
    end
    tick();
    checks++;
    if (commit_count !== 16'd2 || char_valid !== 1'b0) begin
      failures++;
      $display("FAIL count_after_G: count=%0d valid=%b want 2 0", commit_count, char_valid);
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    enable         = 1'b0;
    sample_strobe  = 1'b0;
    ascii_in       = 8'h00;
    ascii_in_valid = 1'b0;
    out_ready      = 1'b0;
    test_reset();
    test_single_commit();
    test_candidate_switch();
    test_backpressure();
    test_wait_neutral();
    test_async_reset();
    test_enable_drop_in_commit();
    test_enable_drop_in_track();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
